// File: rtl/lstm_pkg.sv
// Shared constants, FSM state encoding and fixed-point helpers for the LSTM step engine.
package lstm_pkg;

  localparam int GATE_I = 0;
  localparam int GATE_F = 1;
  localparam int GATE_G = 2;
  localparam int GATE_O = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_ACT,
    ST_UPDATE,
    ST_DONE
  } state_t;

  function automatic int lstm_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int acc_width(input int dw, input int n_ch);
    return 2 * dw + $clog2(2 * n_ch + 1);
  endfunction

  function automatic int sat(input int v, input int dw);
    int hi;
    int lo;
    hi = (1 << (dw - 1)) - 1;
    lo = -(1 << (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int hsig(input int a, input int frac);
    int r;
    r = (a >>> 2) + (lstm_one(frac) >>> 1);
    if (r < 0) return 0;
    if (r > lstm_one(frac)) return lstm_one(frac);
    return r;
  endfunction

  function automatic int htanh(input int a, input int frac);
    if (a > lstm_one(frac)) return lstm_one(frac);
    if (a < -lstm_one(frac)) return -lstm_one(frac);
    return a;
  endfunction

endpackage

// File: rtl/lstm_cell_update.sv
// Combinational per-channel LSTM state update from the four activated gate values.
module lstm_cell_update
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 5
) (
  input  logic signed [DATA_WIDTH-1:0] i_gate,
  input  logic signed [DATA_WIDTH-1:0] f_gate,
  input  logic signed [DATA_WIDTH-1:0] g_gate,
  input  logic signed [DATA_WIDTH-1:0] o_gate,
  input  logic signed [DATA_WIDTH-1:0] c_old,
  output logic signed [DATA_WIDTH-1:0] c_new,
  output logic signed [DATA_WIDTH-1:0] h_new
);

  int fc;
  int ig;
  int c_sat;
  int c_act;
  int h_sat;

  // NOTE: every always_comb target is assigned on every path, so no latch is inferred.
  always_comb begin
    fc    = (int'(f_gate) * int'(c_old)) >>> FRAC_BITS;
    ig    = (int'(i_gate) * int'(g_gate)) >>> FRAC_BITS;
    c_sat = sat(fc + ig, DATA_WIDTH);
    c_act = htanh(c_sat, FRAC_BITS);
    h_sat = sat((int'(o_gate) * c_act) >>> FRAC_BITS, DATA_WIDTH);
    c_new = DATA_WIDTH'(c_sat);
    h_new = DATA_WIDTH'(h_sat);
  end

endmodule

// File: rtl/lstm_step_engine.sv
// One LSTM timestep over N_CH channels with a single time-multiplexed MAC and external weight ROM.
module lstm_step_engine
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 5,
  parameter int N_CH       = 4,
  localparam int W_AW      = $clog2(4 * N_CH * (2 * N_CH + 1))
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clear_state,
  input  logic [N_CH*DATA_WIDTH-1:0] x,
  output logic                       busy,
  output logic                       done,
  output logic [N_CH*DATA_WIDTH-1:0] h_out,
  output logic                       w_rd_en,
  output logic [W_AW-1:0]            w_addr,
  input  logic [DATA_WIDTH-1:0]      w_data
);

  localparam int N_TERMS = 2 * N_CH + 1;
  localparam int ACC_W   = acc_width(DATA_WIDTH, N_CH);
  localparam int T_W     = $clog2(N_TERMS);
  localparam int J_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t                        state;
  logic [1:0]                    gate_k;
  logic [J_W-1:0]                ch_j;
  logic [T_W-1:0]                term_t;
  logic [T_W-1:0]                term_d;
  logic signed [ACC_W-1:0]       acc;
  logic signed [DATA_WIDTH-1:0]  x_lat    [N_CH];
  logic signed [DATA_WIDTH-1:0]  h_state  [N_CH];
  logic signed [DATA_WIDTH-1:0]  c_state  [N_CH];
  logic signed [DATA_WIDTH-1:0]  h_shadow [N_CH];
  logic signed [DATA_WIDTH-1:0]  gate_val [4];

  logic signed [DATA_WIDTH-1:0]   w_s;
  logic signed [DATA_WIDTH-1:0]   operand;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        addend;
  logic signed [ACC_W-1:0]        acc_sh;
  logic signed [DATA_WIDTH-1:0]   gate_next;
  logic signed [DATA_WIDTH-1:0]   c_new;
  logic signed [DATA_WIDTH-1:0]   h_new;

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign w_rd_en = (state == ST_MAC);
  assign w_addr  = W_AW'((int'(gate_k) * N_CH + int'(ch_j)) * N_TERMS + int'(term_t));

  // term_d names the term whose read data is on w_data this cycle; h_state is always h_old.
  always_comb begin
    w_s     = w_data;
    operand = '0;
    for (int n = 0; n < N_CH; n++) begin
      if (int'(term_d) == n)        operand = x_lat[n];
      if (int'(term_d) == N_CH + n) operand = h_state[n];
    end
    prod = w_s * operand;
    if (int'(term_d) == 2 * N_CH) addend = ACC_W'(w_s) <<< FRAC_BITS;
    else                          addend = ACC_W'(prod);
    acc_sh    = acc >>> FRAC_BITS;
    gate_next = DATA_WIDTH'((int'(gate_k) == GATE_G)
                  ? htanh(sat(int'(acc_sh), DATA_WIDTH), FRAC_BITS)
                  : hsig(sat(int'(acc_sh), DATA_WIDTH), FRAC_BITS));
  end

  lstm_cell_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_cell (
    .i_gate (gate_val[GATE_I]),
    .f_gate (gate_val[GATE_F]),
    .g_gate (gate_val[GATE_G]),
    .o_gate (gate_val[GATE_O]),
    .c_old  (c_state[ch_j]),
    .c_new  (c_new),
    .h_new  (h_new)
  );

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      gate_k <= '0;
      ch_j   <= '0;
      term_t <= '0;
      term_d <= '0;
      acc    <= '0;
      h_out  <= '0;
      // NOTE: these small state arrays are flops, not RAM, so they can and must reset.
      for (int n = 0; n < N_CH; n++) begin
        x_lat[n]    <= '0;
        h_state[n]  <= '0;
        c_state[n]  <= '0;
        h_shadow[n] <= '0;
      end
      for (int k = 0; k < 4; k++) gate_val[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Clear lands on the same edge as acceptance, so the step sees h=c=0.
          if (clear_state) begin
            for (int n = 0; n < N_CH; n++) begin
              h_state[n] <= '0;
              c_state[n] <= '0;
            end
          end
          if (start) begin
            for (int n = 0; n < N_CH; n++) x_lat[n] <= x[n*DATA_WIDTH +: DATA_WIDTH];
            gate_k <= '0;
            ch_j   <= '0;
            term_t <= '0;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          term_d <= term_t;
          if (term_t == '0) acc <= '0;
          else              acc <= acc + addend;
          if (int'(term_t) == N_TERMS - 1) state <= ST_DRAIN;
          else                             term_t <= term_t + 1'b1;
        end
        ST_DRAIN: begin
          acc   <= acc + addend;
          state <= ST_ACT;
        end
        ST_ACT: begin
          gate_val[gate_k] <= gate_next;
          term_t           <= '0;
          if (int'(gate_k) == GATE_O) begin
            state <= ST_UPDATE;
          end else begin
            gate_k <= gate_k + 1'b1;
            state  <= ST_MAC;
          end
        end
        ST_UPDATE: begin
          c_state[ch_j]  <= c_new;
          h_shadow[ch_j] <= h_new;
          gate_k         <= '0;
          if (int'(ch_j) == N_CH - 1) begin
            state <= ST_DONE;
          end else begin
            ch_j  <= ch_j + 1'b1;
            state <= ST_MAC;
          end
        end
        ST_DONE: begin
          for (int n = 0; n < N_CH; n++) begin
            h_state[n]                        <= h_shadow[n];
            h_out[n*DATA_WIDTH +: DATA_WIDTH] <= h_shadow[n];
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lstm_step_engine.md
# lstm_step_engine

Parametrised successor to the fixed 4-channel, 8-bit LSTM top. It computes one LSTM timestep for N channels using a single time-multiplexed MAC, fetching weights from an external 1-cycle-latency memory. Hidden and cell state are kept internally, so a sequence runs as repeated `start` pulses with no external feedback of `y_out`. It sits between the input-vector source and the downstream classifier, as a drop-in replacement for the current LSTM top.

## Interface
- `DATA_WIDTH`, 8: signed fixed-point width of x, h, c, weights.
- `FRAC_BITS`, 5: fractional bits; ONE = 1<<FRAC_BITS; requires ONE ≤ 2^(DATA_WIDTH-1)-1.
- `N_CH`, 4: channel count (input dim = hidden dim).
- `W_AW`, derived: weight address width, clog2(4·N_CH·(2·N_CH+1)).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: step request; accepted only in IDLE.
- `clear_state` in 1: zero h and c; accepted only in IDLE.
- `x` in N_CH·DATA_WIDTH: input vector, channel j at bits [j·DW +: DW]; latched on start acceptance.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse when the step commits.
- `h_out` out N_CH·DATA_WIDTH: committed hidden state (registered).
- `w_rd_en` out 1, `w_addr` out W_AW: weight read request.
- `w_data` in DATA_WIDTH: read data, valid exactly 1 cycle after `w_rd_en`.

## Operation
- Gates k ∈ {i=0, f=1, g=2, o=3}. Terms t = 0..2N: t<N → x[t]; N≤t<2N → h_old[t-N]; t=2N → bias.
- Weight address = ((k·N_CH + j)·(2N_CH+1)) + t.
- Accumulator width 2·DW + clog2(2N+1).
  - Product terms add w·operand.
  - The bias term adds w_data<<FRAC_BITS.
  - Pre-activation = sat_DW(acc >>> FRAC_BITS), arithmetic shift.
- Activations:
  - hsig(a) = clamp((a>>>2) + ONE/2, 0, ONE).
  - htanh(a) = clamp(a, -ONE, ONE).
  - i, f, o use hsig; g uses htanh.
- Channel update: c_new = sat(((f·c)>>>F) + ((i·g)>>>F)); h_new = sat((o·htanh(c_new))>>>F).
  - c_new is written immediately.
  - h_new goes to a shadow buffer, so every U·h product uses h_old.
- FSM states:
  - IDLE → MAC on accepted start.
  - MAC issues 2N+1 reads, then → DRAIN, which takes the last data.
  - DRAIN → ACT, which registers the gate value. From ACT: next gate → MAC; after gate o → UPDATE.
  - UPDATE → MAC (next channel) or DONE (last channel).
  - DONE copies shadow to h_out, pulses `done`, then → IDLE.
- `start` or `clear_state` while busy: ignored, not queued.
- `start` and `clear_state` in the same IDLE cycle: state is cleared first, and the step runs with h=c=0.
- Reset, including mid-step:
  - FSM → IDLE.
  - h, c, shadow, h_out = 0.
  - busy, done, w_rd_en = 0; w_addr = 0.
  - The partial step is discarded.

## Timing
- Start accepted in cycle 0. `done` is high in cycle N·(8N+13)+1, which is 181 for N=4.
- Per gate: 2N+1 MAC + 1 DRAIN + 1 ACT cycles. Per channel: 4 gates + 1 UPDATE.
- `w_rd_en` is high only in MAC cycles, with addresses consecutive within a gate.
- h_out changes only on the `done` cycle (registered, visible the next cycle). It is stable otherwise.
- A new start is accepted in the cycle after `done` at the earliest.
- clear_state takes effect next cycle. `busy` stays low.

## Structure
- `lstm_pkg` holds:
  - gate index constants and the FSM state enum;
  - the `hsig`, `htanh` and `sat` functions;
  - ONE and accumulator-width localparams.
- One sub-module, `lstm_cell_update`, is combinational: (i, f, g, o, c_old) → (c_new, h_new).
- Weight memory is external; the bench supplies a behavioural 1-cycle ROM.

## Test plan
- All weights 0, x=any, N=4 → i=f=o=16, g=0; h_out=0, c=0; done at cycle 181 exactly; w_rd_en count = 144.
- Bias-only: b_i=b_o=127, b_g=32, b_f=0 →
  - step 1: c=32, h_out={32,32,32,32};
  - step 2 (no clear): c=48, h_out={32,...}.
- Saturation: x all 127, g weights all 127, others as in the bias-only case → g pre-act saturates to 127, htanh=32; h_out=32, no wrap to negative.
- Recurrence: x weights 0, U_g = identity·32, b_i=b_o=127, b_f=-128 (f=0). Preload h=32 via a prior step → g=32, c=32, h_out=32. Repeat after clear_state: h_out=0.
- start pulsed at cycles 50 and 100 mid-step → ignored; single done at 181; results identical to an unperturbed run.
- rst_n low at cycle 90, high at 92 → busy=0, h_out=0, w_rd_en=0 from cycle 91; a fresh start gives done 181 cycles later with zero-state result.
